sfifo_out_packer: RTL

- DUT-side transmitter for the host streaming FIFO output channel (512-bit data, data-enable, 4-bit length).
- Accepts 64-bit message words from testbench logic over a valid/ready interface and packs up to 8 words into one 512-bit beat.
- Presents each beat to the GFIFO output channel, which backpressures through o_ready.
- A beat closes when it holds 8 words, on an explicit last word, on an external flush, or after an idle timeout.

---
 rtl/sfifo_pkg.sv | 21 ++
 rtl/sfifo_beat_accum.sv | 85 ++++++++
 rtl/sfifo_out_packer.sv | 64 ++++++
 3 files changed

// File: rtl/sfifo_pkg.sv
// Shared widths, beat type and accumulator states for the streaming FIFO output packer.
// No logic; imported by the accumulator and the top.
package sfifo_pkg;

  localparam int SFIFO_DATA_W   = 512;
  localparam int WORD_W         = 64;
  localparam int WORDS_PER_BEAT = 8;
  localparam int LEN_W          = 4;

  typedef struct packed {
    logic [SFIFO_DATA_W-1:0] data;
    logic [LEN_W-1:0]        len;
  } sfifo_beat_t;

  typedef enum logic [1:0] {
    ACC_EMPTY,
    ACC_FILL,
    ACC_CLOSED
  } acc_state_t;

endpackage

// File: rtl/sfifo_beat_accum.sv
// Packs 64-bit words into a beat; closes on 8 words, last, flush or idle timeout.
// Closing beat is offered combinationally via beat_load; with no free slot it parks and in_ready drops.
module sfifo_beat_accum
  import sfifo_pkg::*;
#(
  parameter int FLUSH_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  input  logic              flush_req,
  input  logic              slot_free,
  output logic              beat_load,
  output sfifo_beat_t       beat
);

  localparam int TIMER_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  acc_state_t              state;
  logic [LEN_W-1:0]        count_q;
  logic [LEN_W-1:0]        count_n;
  logic [SFIFO_DATA_W-1:0] data_q;
  logic [SFIFO_DATA_W-1:0] data_n;
  logic [TIMER_W-1:0]      timer_q;
  logic                    accept;
  logic                    timeout;
  logic                    close_evt;

  assign in_ready = (state != ACC_CLOSED);
  assign accept   = in_valid && in_ready;

  // Next-state view including this cycle's word, so a closing word joins its own beat.
  always_comb begin
    data_n  = data_q;
    count_n = count_q;
    if (accept) begin
      data_n[WORD_W*count_q[2:0] +: WORD_W] = in_data;
      count_n = count_q + LEN_W'(1);
    end
  end

  assign timeout = (FLUSH_CYCLES != 0) && !accept && (count_q != '0) &&
                   (timer_q == TIMER_W'(FLUSH_CYCLES - 1));

  assign close_evt = in_ready &&
                     ((accept && ((count_n == LEN_W'(WORDS_PER_BEAT)) || in_last)) ||
                      (flush_req && (count_n != '0)) ||
                      timeout);

  assign beat_load = slot_free && ((state == ACC_CLOSED) || close_evt);
  assign beat      = {data_n, count_n};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ACC_EMPTY;
      count_q <= '0;
      data_q  <= '0;
      timer_q <= '0;
    end else if (beat_load) begin
      state   <= ACC_EMPTY;
      count_q <= '0;
      data_q  <= '0;
      timer_q <= '0;
    end else if (close_evt) begin
      state   <= ACC_CLOSED;
      count_q <= count_n;
      data_q  <= data_n;
    end else if (accept) begin
      state   <= ACC_FILL;
      count_q <= count_n;
      data_q  <= data_n;
      timer_q <= '0;
    end else if (state != ACC_CLOSED) begin
      if (count_q == '0) begin
        timer_q <= '0;
      end else if (timer_q != '1) begin
        timer_q <= timer_q + TIMER_W'(1);
      end
    end
  end

endmodule

// File: rtl/sfifo_out_packer.sv
// Streaming FIFO output transmitter: word accumulator feeding a registered 512-bit beat.
// Closing word to o_data_en is one cycle; beat holds while !o_ready, new beat loads on the handshake edge.
module sfifo_out_packer
  import sfifo_pkg::*;
#(
  parameter int FLUSH_CYCLES = 64,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W-1:0]       in_data,
  input  logic                    in_last,
  input  logic                    flush_req,
  output logic [SFIFO_DATA_W-1:0] o_data,
  output logic                    o_data_en,
  output logic [LEN_W-1:0]        o_data_len,
  input  logic                    o_ready,
  output logic [CNT_W-1:0]        beats_sent
);

  logic        slot_free;
  logic        beat_load;
  sfifo_beat_t beat;

  assign slot_free = !o_data_en || o_ready;

  sfifo_beat_accum #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_accum (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .flush_req (flush_req),
    .slot_free (slot_free),
    .beat_load (beat_load),
    .beat      (beat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_data     <= '0;
      o_data_en  <= 1'b0;
      o_data_len <= '0;
      beats_sent <= '0;
    end else begin
      if (beat_load) begin
        o_data     <= beat.data;
        o_data_len <= beat.len;
        o_data_en  <= 1'b1;
      end else if (o_ready) begin
        o_data_en  <= 1'b0;
      end
      if (o_data_en && o_ready) begin
        beats_sent <= beats_sent + CNT_W'(1);
      end
    end
  end

endmodule
